// File: rtl/leaf_feeder_pkg.sv
// Shared constants and helpers for the leaf feeder and its way buffer.
// Holds the way-count expression and the max-key sentinel builder.
package leaf_feeder_pkg;

   localparam int MAX_DATW = 256;

   function automatic int way_cnt(input int w_log);
      return 1 << w_log;
   endfunction

   function automatic logic [MAX_DATW-1:0] sentinel(input int datw,
                                                    input int keyw);
      logic [MAX_DATW-1:0] s;
      s = '0;
      for (int i = 0; i < MAX_DATW; i++)
         if (i < keyw && i < datw) s[i] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/leaf_feeder_if.sv
// Request, source and response bus between the leaf stage and feeder.
// master drives requests and source records; slave is the feeder.
interface leaf_feeder_if #(
   parameter int W_LOG = 2,
   parameter int DATW  = 64
);
   import leaf_feeder_pkg::*;

   localparam int WAYS = way_cnt(W_LOG);

   logic [W_LOG-1:0] REQ_IN;
   logic             REQ_IN_VALID;
   logic             QUEUE_FULL;
   logic [DATW-1:0]  SRC_DIN;
   logic             SRC_DINEN;
   logic [W_LOG-1:0] SRC_IDX;
   logic [WAYS-1:0]  SRC_DONE;
   logic [WAYS-1:0]  SRC_FULL;
   logic [DATW-1:0]  DOT;
   logic             DOTEN;
   logic [W_LOG-1:0] DOT_IDX;
   logic             ERR_OVF;

   modport master (
      output REQ_IN, REQ_IN_VALID, SRC_DIN, SRC_DINEN, SRC_IDX, SRC_DONE,
      input  QUEUE_FULL, SRC_FULL, DOT, DOTEN, DOT_IDX, ERR_OVF
   );

   modport slave (
      input  REQ_IN, REQ_IN_VALID, SRC_DIN, SRC_DINEN, SRC_IDX, SRC_DONE,
      output QUEUE_FULL, SRC_FULL, DOT, DOTEN, DOT_IDX, ERR_OVF
   );

endinterface

// File: rtl/leaf_way_buffer.sv
// Multi-channel FIFO: one small queue per way, shared storage array.
// Head of the dequeue channel is read combinationally.
module leaf_way_buffer
   import leaf_feeder_pkg::*;
#(
   parameter  int W_LOG     = 2,
   parameter  int FIFO_SIZE = 2,
   parameter  int DATW      = 64,
   localparam int WAYS      = way_cnt(W_LOG)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enq,
   input  logic [W_LOG-1:0] enq_idx,
   input  logic [DATW-1:0]  enq_din,
   input  logic             deq,
   input  logic [W_LOG-1:0] deq_idx,
   output logic [DATW-1:0]  head,
   output logic [WAYS-1:0]  emp,
   output logic [WAYS-1:0]  full
);

   localparam int DEPTH = 1 << FIFO_SIZE;
   localparam logic [FIFO_SIZE:0] DEPTH_C = (FIFO_SIZE+1)'(DEPTH);

   logic [DATW-1:0]      mem [WAYS][DEPTH];
   logic [FIFO_SIZE-1:0] wp  [WAYS];
   logic [FIFO_SIZE-1:0] rp  [WAYS];
   logic [FIFO_SIZE:0]   cnt [WAYS];
   logic [WAYS-1:0]      wr_v;
   logic [WAYS-1:0]      rd_v;
   logic                 wr_ok;

   // a full way still accepts a write if it is dequeued in the same cycle
   assign wr_ok = enq && (!full[enq_idx] || (deq && deq_idx == enq_idx));
   assign head  = mem[deq_idx][rp[deq_idx]];

   // per-way status flags and one-hot write/read strobes
   always_comb begin
      wr_v = '0;
      rd_v = '0;
      for (int k = 0; k < WAYS; k++) begin
         emp[k]  = (cnt[k] == '0);
         full[k] = (cnt[k] == DEPTH_C);
      end
      wr_v[enq_idx] = wr_ok;
      rd_v[deq_idx] = deq && !emp[deq_idx];
   end

   // pointer and occupancy bookkeeping per way
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < WAYS; k++) begin
            wp[k]  <= '0;
            rp[k]  <= '0;
            cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < WAYS; k++) begin
            if (wr_v[k]) wp[k] <= wp[k] + 1'b1;
            if (rd_v[k]) rp[k] <= rp[k] + 1'b1;
            case ({wr_v[k], rd_v[k]})
               2'b10:   cnt[k] <= cnt[k] + 1'b1;
               2'b01:   cnt[k] <= cnt[k] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // record storage, no reset needed since occupancy gates every read
   always_ff @(posedge CLK) begin
      if (wr_ok) mem[enq_idx][wp[enq_idx]] <= enq_din;
   end

endmodule

// File: rtl/leaf_feeder.sv
// Leaf-side responder: queues way requests, serves buffered records
// in order, and substitutes a max-key sentinel for exhausted ways.
module leaf_feeder
   import leaf_feeder_pkg::*;
#(
   parameter int W_LOG     = 2,
   parameter int FIFO_SIZE = 2,
   parameter int DATW      = 64,
   parameter int KEYW      = 32
) (
   input logic           CLK,
   input logic           RST,
   leaf_feeder_if.slave  bus
);

   localparam int WAYS = way_cnt(W_LOG);
   localparam logic [MAX_DATW-1:0] SENT_FULL = sentinel(DATW, KEYW);
   localparam logic [DATW-1:0] SENT = SENT_FULL[DATW-1:0];

   logic [W_LOG-1:0] q [2];
   logic             q_wp, q_rp;
   logic [1:0]       q_cnt;
   logic [1:0]       rdy;
   logic [W_LOG-1:0] h;
   logic             elig;
   logic             serve_data, serve_sent, serve;
   logic             q_push, q_ovf, w_ovf;
   logic [DATW-1:0]  head;
   logic [WAYS-1:0]  emp, full;
   logic [DATW-1:0]  dot_r;
   logic             doten_r;
   logic [W_LOG-1:0] dot_idx_r;
   logic             err_r;

   // an entry becomes servable one cycle after it is enqueued
   assign h          = q[q_rp];
   assign elig       = (q_cnt != 2'd0) && rdy[q_rp];
   assign serve_data = elig && !emp[h];
   assign serve_sent = elig && emp[h] && bus.SRC_DONE[h];
   assign serve      = serve_data || serve_sent;
   assign q_push     = bus.REQ_IN_VALID && (q_cnt != 2'd2 || serve);
   assign q_ovf      = bus.REQ_IN_VALID && q_cnt == 2'd2 && !serve;
   assign w_ovf      = bus.SRC_DINEN && full[bus.SRC_IDX]
                       && !(serve_data && h == bus.SRC_IDX);

   assign bus.QUEUE_FULL = (q_cnt == 2'd2);
   assign bus.SRC_FULL   = full;
   assign bus.DOT        = dot_r;
   assign bus.DOTEN      = doten_r;
   assign bus.DOT_IDX    = dot_idx_r;
   assign bus.ERR_OVF    = err_r;

   leaf_way_buffer #(
      .W_LOG     (W_LOG),
      .FIFO_SIZE (FIFO_SIZE),
      .DATW      (DATW)
   ) u_buf (
      .CLK     (CLK),
      .RST     (RST),
      .enq     (bus.SRC_DINEN),
      .enq_idx (bus.SRC_IDX),
      .enq_din (bus.SRC_DIN),
      .deq     (serve_data),
      .deq_idx (h),
      .head    (head),
      .emp     (emp),
      .full    (full)
   );

   // two-entry request queue with per-slot age bits
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q[0]  <= '0;
         q[1]  <= '0;
         q_wp  <= 1'b0;
         q_rp  <= 1'b0;
         q_cnt <= 2'd0;
         rdy   <= 2'b00;
      end else begin
         rdy <= 2'b11;
         if (q_push) begin
            q[q_wp]   <= bus.REQ_IN;
            q_wp      <= ~q_wp;
            rdy[q_wp] <= 1'b0;
         end
         if (serve) q_rp <= ~q_rp;
         case ({q_push, serve})
            2'b10:   q_cnt <= q_cnt + 2'd1;
            2'b01:   q_cnt <= q_cnt - 2'd1;
            default: ;
         endcase
      end
   end

   // response register; data and index hold while idle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dot_r     <= '0;
         doten_r   <= 1'b0;
         dot_idx_r <= '0;
      end else begin
         doten_r <= serve;
         if (serve) begin
            dot_r     <= serve_data ? head : SENT;
            dot_idx_r <= h;
         end
      end
   end

   // sticky overflow flag for dropped requests or records
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_r <= 1'b0;
      else     err_r <= err_r | q_ovf | w_ovf;
   end

endmodule

// File: tb/tb_leaf_feeder.sv
// Directed bench for leaf_feeder: latency, stall, sentinel,
// overflow, full-buffer bypass and asynchronous reset.
module tb_leaf_feeder;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cnt;

   leaf_feeder_if #(.W_LOG(2), .DATW(64)) bus ();

   leaf_feeder #(
      .W_LOG(2), .FIFO_SIZE(2), .DATW(64), .KEYW(32)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic src_wr(input logic [1:0] idx, input logic [63:0] d);
      bus.SRC_IDX   = idx;
      bus.SRC_DIN   = d;
      bus.SRC_DINEN = 1'b1;
      step();
      bus.SRC_DINEN = 1'b0;
   endtask

   task automatic req(input logic [1:0] idx);
      bus.REQ_IN       = idx;
      bus.REQ_IN_VALID = 1'b1;
      step();
      bus.REQ_IN_VALID = 1'b0;
   endtask

   initial begin
      bus.REQ_IN       = '0;
      bus.REQ_IN_VALID = 1'b0;
      bus.SRC_DIN      = '0;
      bus.SRC_DINEN    = 1'b0;
      bus.SRC_IDX      = '0;
      bus.SRC_DONE     = '0;

      // reset state
      #2 RST = 1'b1;
      step();
      step();
      chk("rst_dot",   bus.DOT, 64'h0);
      chk("rst_doten", bus.DOTEN, 1'b0);
      chk("rst_idx",   bus.DOT_IDX, 2'd0);
      chk("rst_err",   bus.ERR_OVF, 1'b0);
      chk("rst_qfull", bus.QUEUE_FULL, 1'b0);
      chk("rst_sfull", bus.SRC_FULL, 4'h0);
      RST = 1'b0;
      step();

      // way1 keys 5, 9; two back-to-back requests
      src_wr(2'd1, 64'h0000_00A1_0000_0005);
      src_wr(2'd1, 64'h0000_00A1_0000_0009);
      bus.REQ_IN       = 2'd1;
      bus.REQ_IN_VALID = 1'b1;
      step();
      step();
      bus.REQ_IN_VALID = 1'b0;
      chk("t1_early", bus.DOTEN, 1'b0);
      step();
      chk("t1_en0",  bus.DOTEN, 1'b1);
      chk("t1_dot0", bus.DOT, 64'h0000_00A1_0000_0005);
      chk("t1_idx0", bus.DOT_IDX, 2'd1);
      step();
      chk("t1_en1",  bus.DOTEN, 1'b1);
      chk("t1_dot1", bus.DOT, 64'h0000_00A1_0000_0009);
      chk("t1_idx1", bus.DOT_IDX, 2'd1);
      step();
      chk("t1_idle", bus.DOTEN, 1'b0);
      chk("t1_hold", bus.DOT, 64'h0000_00A1_0000_0009);

      // stall on empty way2, then release with one record
      req(2'd2);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         cnt += int'(bus.DOTEN);
      end
      chk("t2_stall", 64'(cnt), 64'd0);
      src_wr(2'd2, 64'h0000_00B2_0000_0030);
      chk("t2_wr_en", bus.DOTEN, 1'b0);
      step();
      chk("t2_en",  bus.DOTEN, 1'b1);
      chk("t2_dot", bus.DOT, 64'h0000_00B2_0000_0030);
      chk("t2_idx", bus.DOT_IDX, 2'd2);

      // way3: data first, then sentinels
      src_wr(2'd3, 64'h0000_00C3_0000_0007);
      bus.SRC_DONE     = 4'b1000;
      bus.REQ_IN       = 2'd3;
      bus.REQ_IN_VALID = 1'b1;
      step();
      step();
      step();
      bus.REQ_IN_VALID = 1'b0;
      chk("t3_en0",  bus.DOTEN, 1'b1);
      chk("t3_dot0", bus.DOT, 64'h0000_00C3_0000_0007);
      chk("t3_idx0", bus.DOT_IDX, 2'd3);
      step();
      chk("t3_en1",  bus.DOTEN, 1'b1);
      chk("t3_dot1", bus.DOT, 64'h0000_0000_FFFF_FFFF);
      step();
      chk("t3_en2",  bus.DOTEN, 1'b1);
      chk("t3_dot2", bus.DOT, 64'h0000_0000_FFFF_FFFF);
      chk("t3_idx2", bus.DOT_IDX, 2'd3);
      step();
      chk("t3_idle", bus.DOTEN, 1'b0);

      // fill way0, then write and serve on it together
      for (int i = 0; i < 4; i++)
         src_wr(2'd0, 64'h0000_00D0_0000_00C0 + 64'(i));
      chk("t5_full", bus.SRC_FULL, 4'b0001);
      chk("t5_err0", bus.ERR_OVF, 1'b0);
      req(2'd0);
      step();
      bus.SRC_IDX   = 2'd0;
      bus.SRC_DIN   = 64'h0000_00D0_0000_00C4;
      bus.SRC_DINEN = 1'b1;
      step();
      bus.SRC_DINEN = 1'b0;
      chk("t5_en",    bus.DOTEN, 1'b1);
      chk("t5_dot",   bus.DOT, 64'h0000_00D0_0000_00C0);
      chk("t5_full1", bus.SRC_FULL, 4'b0001);
      chk("t5_err1",  bus.ERR_OVF, 1'b0);
      bus.REQ_IN = 2'd0;
      for (int i = 0; i < 6; i++) begin
         bus.REQ_IN_VALID = (i < 4);
         step();
         if (i >= 2) begin
            chk("t5_drain_en", bus.DOTEN, 1'b1);
            chk("t5_drain", bus.DOT, 64'h0000_00D0_0000_00C0 + 64'(i - 1));
         end
      end
      bus.REQ_IN_VALID = 1'b0;
      chk("t5_empty", bus.SRC_FULL, 4'b0000);

      // queue full and request overflow on empty way0
      bus.REQ_IN       = 2'd0;
      bus.REQ_IN_VALID = 1'b1;
      step();
      step();
      chk("t4_qfull", bus.QUEUE_FULL, 1'b1);
      chk("t4_err0",  bus.ERR_OVF, 1'b0);
      step();
      bus.REQ_IN_VALID = 1'b0;
      chk("t4_err1",  bus.ERR_OVF, 1'b1);
      cnt = 0;
      src_wr(2'd0, 64'h0000_00E0_0000_00D0);
      cnt += int'(bus.DOTEN);
      src_wr(2'd0, 64'h0000_00E0_0000_00D1);
      cnt += int'(bus.DOTEN);
      for (int i = 0; i < 10; i++) begin
         step();
         cnt += int'(bus.DOTEN);
      end
      chk("t4_resp", 64'(cnt), 64'd2);
      chk("t4_qempty", bus.QUEUE_FULL, 1'b0);
      chk("t4_last", bus.DOT, 64'h0000_00E0_0000_00D1);

      // asynchronous reset with pending work
      for (int i = 0; i < 4; i++)
         src_wr(2'd1, 64'h0000_00F1_0000_00E0 + 64'(i));
      chk("t6_sfull", bus.SRC_FULL, 4'b0010);
      bus.REQ_IN       = 2'd2;
      bus.REQ_IN_VALID = 1'b1;
      step();
      step();
      bus.REQ_IN_VALID = 1'b0;
      chk("t6_qfull", bus.QUEUE_FULL, 1'b1);
      #3 RST = 1'b1;
      bus.SRC_DONE = '0;
      #1;
      chk("t6_dot",   bus.DOT, 64'h0);
      chk("t6_doten", bus.DOTEN, 1'b0);
      chk("t6_idx",   bus.DOT_IDX, 2'd0);
      chk("t6_err",   bus.ERR_OVF, 1'b0);
      chk("t6_qf",    bus.QUEUE_FULL, 1'b0);
      chk("t6_sf",    bus.SRC_FULL, 4'h0);
      step();
      step();
      RST = 1'b0;
      req(2'd1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         cnt += int'(bus.DOTEN);
      end
      chk("t6_stall", 64'(cnt), 64'd0);
      chk("t6_sf2",   bus.SRC_FULL, 4'h0);
      chk("t6_err2",  bus.ERR_OVF, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
